// File: rtl/apb4_mst_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_mst_pkg
// Description : Shared types and constants for the APB4 completer front end.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_mst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam int          PROT_PRIV_BIT    = 0;
    localparam logic [31:0] TMOUT_RDATA_DFLT = 32'hdead_1eaf;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb4_mst_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : apb4_mst_fsm_if
// Description : APB4 completer bus plus reg_native request/response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb4_mst_fsm_if
    import apb_mst_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = strb_width(DATA_WIDTH);

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic [2:0]            pprot;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_WIDTH-1:0] prdata;

    logic                  fsm_req_vld;
    logic                  fsm_wr_en;
    logic                  fsm_rd_en;
    logic [ADDR_WIDTH-1:0] fsm_addr;
    logic [DATA_WIDTH-1:0] fsm_wr_data;
    logic [STRB_WIDTH-1:0] fsm_wr_strb;
    logic                  fsm_ack_vld;
    logic [DATA_WIDTH-1:0] fsm_rd_data;
    logic                  err_acc_dummy;
    logic                  tmout_evt;

    // The front end itself
    modport master (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  fsm_ack_vld, fsm_rd_data, err_acc_dummy,
        output pready, pslverr, prdata,
        output fsm_req_vld, fsm_wr_en, fsm_rd_en, fsm_addr, fsm_wr_data, fsm_wr_strb,
        output tmout_evt
    );

    // Surrounding fabric and register block
    modport slave (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output fsm_ack_vld, fsm_rd_data, err_acc_dummy,
        input  pready, pslverr, prdata,
        input  fsm_req_vld, fsm_wr_en, fsm_rd_en, fsm_addr, fsm_wr_data, fsm_wr_strb,
        input  tmout_evt
    );

endinterface
`default_nettype wire

// File: rtl/apb4_mst_fsm_tmout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mst_tmout_cnt
// Description : Saturating WAIT-cycle counter with terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mst_tmout_cnt #(
    parameter int TMR_WIDTH    = 8,
    parameter int TMOUT_CYCLES = 255
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic en,
    output logic      tmout
);

    logic [TMR_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + TMR_WIDTH'(1);
        end
    end

    generate
        if (TMOUT_CYCLES == 0) begin : g_tmout_off
            logic w_unused_cnt;
            assign w_unused_cnt = ^r_cnt;
            assign tmout        = 1'b0;
        end else begin : g_tmout_on
            // Count starts at 0 in the first WAIT cycle, so TMOUT_CYCLES-1 marks the last one
            localparam logic [TMR_WIDTH-1:0] c_LAST = TMR_WIDTH'(TMOUT_CYCLES - 1);
            assign tmout = (r_cnt == c_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb4_mst_fsm.sv
`default_nettype none
// ============================================================================
// Module      : apb4_mst_fsm
// Description : APB4 completer front end issuing single-pulse reg_native requests.
// Revision    : 1.0 - initial release
// ============================================================================
module apb4_mst_fsm
    import apb_mst_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 64,
    parameter int          DATA_WIDTH   = 32,
    parameter int          TMR_WIDTH    = 8,
    parameter int          TMOUT_CYCLES = 255,
    parameter logic [31:0] TMOUT_RDATA  = TMOUT_RDATA_DFLT,
    parameter int          PRIV_ONLY    = 0
) (
    input  wire logic       pclk,
    input  wire logic       presetn,
    apb4_mst_fsm_if.master  bus
);

    localparam int                    STRB_WIDTH    = strb_width(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_TMOUT_RDATA = DATA_WIDTH'(TMOUT_RDATA);

    state_t                r_state;
    state_t                w_next;
    logic                  r_wr;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_setup;
    logic                  w_priv_ok;
    logic                  w_cnt_clr;
    logic                  w_cnt_en;
    logic                  w_tmout;
    logic                  w_cap;
    logic                  w_unused;

    logic                  w_req_vld;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_WIDTH-1:0] w_wr_strb;
    logic                  w_pready;
    logic                  w_pslverr;
    logic [DATA_WIDTH-1:0] w_prdata;
    logic                  w_tmout_evt;

    assign w_setup   = bus.psel & ~bus.penable;
    assign w_priv_ok = (PRIV_ONLY == 0) || bus.pprot[PROT_PRIV_BIT];
    assign w_unused  = ^bus.pprot;

    mst_tmout_cnt #(
        .TMR_WIDTH    (TMR_WIDTH),
        .TMOUT_CYCLES (TMOUT_CYCLES)
    ) u_tmout_cnt (
        .clk   (pclk),
        .rst_n (presetn),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .tmout (w_tmout)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_setup) begin
                r_wr <= bus.pwrite;
            end
            if (w_cap) begin
                r_rdata <= bus.pwrite ? '0 : bus.fsm_rd_data;
                r_err   <= bus.err_acc_dummy;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        w_cap       = 1'b0;
        w_req_vld   = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_addr      = '0;
        w_wr_data   = '0;
        w_wr_strb   = '0;
        w_pready    = 1'b0;
        w_pslverr   = 1'b0;
        w_prdata    = '0;
        w_tmout_evt = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // A bare fsm_ack_vld here is a late ack after a timeout and is dropped
                if (w_setup) begin
                    if (!w_priv_ok) begin
                        w_next = ST_ERR;
                    end else begin
                        w_req_vld = 1'b1;
                        w_wr_en   = bus.pwrite;
                        w_rd_en   = ~bus.pwrite;
                        w_addr    = bus.paddr;
                        w_wr_data = bus.pwdata;
                        w_wr_strb = bus.pwrite ? bus.pstrb : '0;
                        if (bus.fsm_ack_vld) begin
                            w_cap  = 1'b1;
                            w_next = ST_ACK;
                        end else begin
                            w_cnt_clr = 1'b1;
                            w_next    = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.psel) begin
                    w_next = ST_IDLE;
                end else begin
                    w_cnt_en = 1'b1;
                    if (bus.fsm_ack_vld) begin
                        w_pready  = 1'b1;
                        w_pslverr = bus.err_acc_dummy;
                        w_prdata  = r_wr ? '0 : bus.fsm_rd_data;
                        w_next    = ST_IDLE;
                    end else if (w_tmout) begin
                        w_pready    = 1'b1;
                        w_pslverr   = 1'b1;
                        w_prdata    = r_wr ? '0 : c_TMOUT_RDATA;
                        w_tmout_evt = 1'b1;
                        w_next      = ST_IDLE;
                    end
                end
            end
            ST_ACK: begin
                w_next = ST_IDLE;
                if (bus.psel) begin
                    w_pready  = 1'b1;
                    w_pslverr = r_err;
                    w_prdata  = r_rdata;
                end
            end
            ST_ERR: begin
                w_next = ST_IDLE;
                if (bus.psel) begin
                    w_pready  = 1'b1;
                    w_pslverr = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.fsm_req_vld = w_req_vld;
    assign bus.fsm_wr_en   = w_wr_en;
    assign bus.fsm_rd_en   = w_rd_en;
    assign bus.fsm_addr    = w_addr;
    assign bus.fsm_wr_data = w_wr_data;
    assign bus.fsm_wr_strb = w_wr_strb;
    assign bus.pready      = w_pready;
    assign bus.pslverr     = w_pslverr;
    assign bus.prdata      = w_prdata;
    assign bus.tmout_evt   = w_tmout_evt;

endmodule
`default_nettype wire

// File: tb/tb_apb4_mst_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb4_mst_fsm
// Description : Scoreboard bench for apb4_mst_fsm (PRIV_ONLY=1, TMOUT_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb4_mst_fsm;
    import apb_mst_pkg::*;

    localparam int AW  = 64;
    localparam int DW  = 32;
    localparam int TMO = 4;

    typedef struct {
        logic [31:0] prdata;
        logic        pslverr;
        logic        tmout;
        int          len;
    } rsp_t;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    rsp_t sb_q[$];

    always #5 pclk = ~pclk;

    apb4_mst_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb4_mst_fsm #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .TMR_WIDTH    (8),
        .TMOUT_CYCLES (TMO),
        .TMOUT_RDATA  (32'hdead_1eaf),
        .PRIV_ONLY    (1)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive_idle(input logic ack);
        bus.psel          = 1'b0;
        bus.penable       = 1'b0;
        bus.pwrite        = 1'b0;
        bus.paddr         = '0;
        bus.pwdata        = '0;
        bus.pstrb         = '0;
        bus.pprot         = '0;
        bus.fsm_ack_vld   = ack;
        bus.fsm_rd_data   = 32'h5555_aaaa;
        bus.err_acc_dummy = 1'b0;
    endtask

    task automatic idle_cycle(input logic ack);
        @(posedge pclk);
        #1 drive_idle(ack);
        @(negedge pclk);
        chk("idle_quiet", {bus.pready, bus.pslverr, bus.prdata, bus.tmout_evt, bus.fsm_req_vld}, '0);
    endtask

    // ack_at: 0 = ack in setup cycle, k = ack in k-th WAIT cycle, -1 = never
    task automatic xfer(input logic wr, input logic [63:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic [2:0] prot, input int ack_at,
                        input logic [31:0] rd, input logic err);
        rsp_t e;
        logic allowed;
        logic done;
        allowed = prot[0];
        if (!allowed) begin
            e = '{32'h0, 1'b1, 1'b0, 2};
        end else if (ack_at == 0) begin
            e = '{(wr ? 32'h0 : rd), err, 1'b0, 2};
        end else if (ack_at > 0 && ack_at <= TMO) begin
            e = '{(wr ? 32'h0 : rd), err, 1'b0, 1 + ack_at};
        end else begin
            e = '{(wr ? 32'h0 : 32'hdead_1eaf), 1'b1, 1'b1, 1 + TMO};
        end
        sb_q.push_back(e);

        @(posedge pclk);
        #1;
        bus.psel          = 1'b1;
        bus.penable       = 1'b0;
        bus.pwrite        = wr;
        bus.paddr         = addr;
        bus.pwdata        = wd;
        bus.pstrb         = strb;
        bus.pprot         = prot;
        bus.fsm_rd_data   = rd;
        bus.err_acc_dummy = err;
        bus.fsm_ack_vld   = (ack_at == 0);
        @(negedge pclk);
        chk("setup_req_vld", bus.fsm_req_vld, allowed);
        chk("setup_pready", bus.pready, 1'b0);
        if (allowed) begin
            chk("setup_wr_en", bus.fsm_wr_en, wr);
            chk("setup_rd_en", bus.fsm_rd_en, !wr);
            chk("setup_addr", bus.fsm_addr, addr);
            chk("setup_wdata", bus.fsm_wr_data, wd);
            chk("setup_strb", bus.fsm_wr_strb, wr ? strb : 4'h0);
        end else begin
            chk("setup_noreq", {bus.fsm_wr_en, bus.fsm_rd_en, bus.fsm_wr_strb}, '0);
        end

        done = 1'b0;
        for (int n = 2; n <= 20 && !done; n++) begin
            @(posedge pclk);
            #1;
            bus.penable     = 1'b1;
            bus.fsm_ack_vld = (ack_at == n - 1);
            @(negedge pclk);
            chk("access_no_req", bus.fsm_req_vld, 1'b0);
            if (bus.pready) begin
                done = 1'b1;
                chk("sb_nonempty", sb_q.size(), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("rsp_prdata", bus.prdata, e.prdata);
                    chk("rsp_pslverr", bus.pslverr, e.pslverr);
                    chk("rsp_tmout_evt", bus.tmout_evt, e.tmout);
                    chk("rsp_len", n, e.len);
                end
            end else begin
                chk("wait_quiet", {bus.pslverr, bus.prdata, bus.tmout_evt}, '0);
            end
        end
        if (!done) begin
            chk("pready_bound", done, 1'b1);
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        drive_idle(1'b0);
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("reset_quiet", {bus.pready, bus.pslverr, bus.prdata, bus.tmout_evt, bus.fsm_req_vld}, '0);
        @(posedge pclk);
        #1 presetn = 1'b1;

        // Zero-wait read
        xfer(1'b0, 64'h10, 32'h0, 4'h0, 3'b001, 0, 32'h1234_5678, 1'b0);
        // Write, ack in 3rd WAIT cycle
        xfer(1'b1, 64'h20, 32'ha5a5_5a5a, 4'b0101, 3'b001, 3, 32'hffff_ffff, 1'b0);
        // Read timeout, then a late ack two cycles later
        xfer(1'b0, 64'h30, 32'h0, 4'h0, 3'b001, -1, 32'h0bad_0bad, 1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        xfer(1'b0, 64'h34, 32'h0, 4'h0, 3'b001, 1, 32'hcafe_f00d, 1'b0);
        // Ack coinciding with timeout cycle
        xfer(1'b0, 64'h40, 32'h0, 4'h0, 3'b001, TMO, 32'h0000_beef, 1'b1);
        // Privilege violation with an ack present in setup
        xfer(1'b0, 64'h50, 32'h0, 4'h0, 3'b000, 0, 32'h7777_7777, 1'b0);
        // Back-to-back zero-wait write with downstream error
        xfer(1'b1, 64'hffff_0000_0000_0058, 32'h1357_9bdf, 4'b1111, 3'b011, 0, 32'h2222_2222, 1'b1);
        // Write timeout returns zero data
        xfer(1'b1, 64'h60, 32'h0f0f_0f0f, 4'b1000, 3'b001, -1, 32'h3333_3333, 1'b0);
        idle_cycle(1'b0);

        // Reset pulsed mid-WAIT
        @(posedge pclk);
        #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 64'h70; bus.pprot = 3'b001; bus.fsm_ack_vld = 1'b0;
        repeat (3) begin
            @(posedge pclk);
            #1 bus.penable = 1'b1;
        end
        presetn = 1'b0;
        @(negedge pclk);
        chk("reset_mid_wait", {bus.pready, bus.pslverr, bus.prdata, bus.tmout_evt, bus.fsm_req_vld}, '0);
        @(posedge pclk);
        #1;
        drive_idle(1'b0);
        presetn = 1'b1;
        @(negedge pclk);
        chk("post_reset_quiet", {bus.pready, bus.pslverr, bus.tmout_evt}, '0);
        xfer(1'b0, 64'h74, 32'h0, 4'h0, 3'b001, -1, 32'h0, 1'b0);
        xfer(1'b0, 64'h78, 32'h0, 4'h0, 3'b001, 2, 32'h8765_4321, 1'b0);
        idle_cycle(1'b0);

        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
